// File: rtl/mem_access_ctrl.sv
// Load/store controller in front of a single-port word-addressed RAM; sub-word stores use read-modify-write.
// Optional build macro MEMCTL_BOUNDS_CHECK_EN turns out-of-range addresses into error responses.
module mem_access_ctrl #(
  parameter int ADDR_W   = 16,
  parameter int DEPTH    = 51200,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              mem_en,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_din,
  input  logic [31:0]       mem_dout
);

  // state | meaning
  // IDLE  | ready for a request
  // RD    | RAM read strobe
  // WAIT  | waiting READ_LAT cycles for mem_dout
  // WR    | RAM write strobe
  // RESP  | one-cycle response pulse
  typedef enum logic [2:0] {IDLE, RD, WAIT, WR, RESP} state_t;

  state_t            state;
  logic              r_we;
  logic [1:0]        r_size;
  logic              r_signed;
  logic [1:0]        r_lane;
  logic [31:0]       r_wdata;
  logic [1:0]        wait_cnt;
  logic              req_err;
  logic [ADDR_W-1:0] word_idx;
  logic [31:0]       merged;
  logic [31:0]       ld_data;
  logic [4:0]        byte_sh;
  logic [4:0]        half_sh;
  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;

  assign word_idx  = req_addr[ADDR_W+1:2];
  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign mem_en    = (state == RD) || (state == WR);
  assign mem_wen   = (state == WR);

`ifndef MEMCTL_BOUNDS_CHECK_EN
  wire unused_addr_hi = &{1'b0, req_addr[31:ADDR_W+2]};
`endif

  always_comb begin
    req_err = 1'b0;
    case (req_size)
      2'b00:   req_err = 1'b0;
      2'b01:   req_err = req_addr[0];
      2'b10:   req_err = |req_addr[1:0];
      default: req_err = 1'b1;
    endcase
`ifdef MEMCTL_BOUNDS_CHECK_EN
    if ((32'(word_idx) >= 32'(DEPTH)) || (|req_addr[31:ADDR_W+2]))
      req_err = 1'b1;
`endif
  end

  // Big-endian lanes: lane 0 is the most significant byte, so shift = (3 - lane) * 8.
  always_comb begin
    byte_sh  = {~r_lane, 3'b000};
    half_sh  = {~r_lane[1], 4'b0000};
    byte_sel = 8'(mem_dout >> byte_sh);
    half_sel = 16'(mem_dout >> half_sh);
    merged   = mem_dout;
    ld_data  = mem_dout;
    case (r_size)
      2'b00: begin
        merged  = (mem_dout & ~(32'h0000_00FF << byte_sh)) | ({24'd0, r_wdata[7:0]} << byte_sh);
        ld_data = r_signed ? {{24{byte_sel[7]}}, byte_sel} : {24'd0, byte_sel};
      end
      2'b01: begin
        merged  = (mem_dout & ~(32'h0000_FFFF << half_sh)) | ({16'd0, r_wdata[15:0]} << half_sh);
        ld_data = r_signed ? {{16{half_sel[15]}}, half_sel} : {16'd0, half_sel};
      end
      default: begin
        merged  = r_wdata;
        ld_data = mem_dout;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      r_we      <= 1'b0;
      r_size    <= 2'b00;
      r_signed  <= 1'b0;
      r_lane    <= 2'b00;
      r_wdata   <= 32'd0;
      wait_cnt  <= 2'd0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
      mem_addr  <= '0;
      mem_din   <= 32'd0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          r_we     <= req_we;
          r_size   <= req_size;
          r_signed <= req_signed;
          r_lane   <= req_addr[1:0];
          r_wdata  <= req_wdata;
          if (req_err) begin
            rsp_err   <= 1'b1;
            rsp_rdata <= 32'd0;
            state     <= RESP;
          end else begin
            mem_addr <= word_idx;
            if (req_we && (req_size == 2'b10)) begin
              mem_din <= req_wdata;
              state   <= WR;
            end else begin
              state <= RD;
            end
          end
        end
        RD: begin
          wait_cnt <= 2'(READ_LAT - 1);
          state    <= WAIT;
        end
        WAIT: begin
          if (wait_cnt == 2'd0) begin
            if (r_we) begin
              mem_din <= merged;
              state   <= WR;
            end else begin
              rsp_rdata <= ld_data;
              state     <= RESP;
            end
          end else begin
            wait_cnt <= wait_cnt - 2'd1;
          end
        end
        WR: state <= RESP;
        RESP: begin
          rsp_err   <= 1'b0;
          rsp_rdata <= 32'd0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed scenarios plus random traffic against a reference model.
module tb_mem_access_ctrl;
  localparam int ADDR_W = 16;
  localparam int DEPTH  = 51200;
  localparam int RL     = 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_we = 1'b0;
  logic [1:0]        req_size = 2'b00;
  logic              req_signed = 1'b0;
  logic [31:0]       req_addr = 32'd0;
  logic [31:0]       req_wdata = 32'd0;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic              mem_en;
  logic              mem_wen;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_din;
  logic [31:0]       mem_dout = 32'd0;

  int checks = 0;
  int failures = 0;

  mem_access_ctrl #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .READ_LAT(RL)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .mem_en(mem_en),
    .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  // RAM model (one-cycle read latency), independent of the reference memory
  logic [31:0] ram [int];
  function automatic logic [31:0] ram_rd(input int a);
    return ram.exists(a) ? ram[a] : 32'd0;
  endfunction
  always @(posedge clk) begin
    if (mem_en && !mem_wen) mem_dout <= ram_rd(int'(mem_addr));
    if (mem_en && mem_wen) ram[int'(mem_addr)] = mem_din;
  end

  logic [31:0] ref_mem [int];
  function automatic logic [31:0] ref_rd(input int a);
    return ref_mem.exists(a) ? ref_mem[a] : 32'd0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected outcome from the architectural rules, plain arithmetic on byte offsets.
  task automatic ref_req(input bit we, input logic [1:0] size, input bit sgn, input logic [31:0] addr,
                         input logic [31:0] wdata, output bit err, output logic [31:0] rdata,
                         output int lat, output logic [31:0] idx);
    logic [31:0] old, v, sh, nw;
    int lane;
    lane = int'(addr % 4);
    idx  = (addr / 4) % 65536;
    err  = (size == 2'd3) || (size == 2'd1 && (addr % 2) != 0) || (size == 2'd2 && (addr % 4) != 0);
`ifdef MEMCTL_BOUNDS_CHECK_EN
    if ((addr / 4) >= DEPTH) err = 1'b1;
`endif
    old = ref_rd(int'(idx));
    rdata = 32'd0;
    if (err) begin
      lat = 1;
    end else if (!we) begin
      lat = 2 + RL;
      if (size == 2'd2) rdata = old;
      else if (size == 2'd0) begin
        v = (old >> (8 * (3 - lane))) % 256;
        rdata = (sgn && v >= 128) ? v - 256 : v;
      end else begin
        v = (old >> (16 * (1 - lane / 2))) % 65536;
        rdata = (sgn && v >= 32768) ? v - 65536 : v;
      end
    end else begin
      if (size == 2'd2) begin
        lat = 2;
        nw  = wdata;
      end else if (size == 2'd0) begin
        lat = 3 + RL;
        sh  = 8 * (3 - lane);
        nw  = old - (((old >> sh) % 256) << sh) + ((wdata % 256) << sh);
      end else begin
        lat = 3 + RL;
        sh  = 16 * (1 - lane / 2);
        nw  = old - (((old >> sh) % 65536) << sh) + ((wdata % 65536) << sh);
      end
      ref_mem[int'(idx)] = nw;
    end
  endtask

  task automatic drive(input bit we, input logic [1:0] size, input bit sgn, input logic [31:0] addr,
                       input logic [31:0] wdata);
    req_valid  = 1'b1;
    req_we     = we;
    req_size   = size;
    req_signed = sgn;
    req_addr   = addr;
    req_wdata  = wdata;
  endtask

  // Called right at the accepting clock edge; k counts cycles after acceptance.
  task automatic collect(input string tag, input bit e_err, input logic [31:0] e_rd, input int e_lat,
                         input logic [31:0] e_idx, input bit e_wr, output logic [31:0] got);
    bit seen_en = 0, seen_wr = 0;
    int lat = -1, wr_k = -1;
    logic [31:0] g_idx = 32'd0;
    logic g_err = 1'bx;
    got = 32'hxxxxxxxx;
    for (int k = 1; k <= 16; k++) begin
      #1;
      req_valid = 1'b0;
      if (mem_en) begin
        seen_en = 1;
        g_idx = 32'(mem_addr);
        if (mem_wen && !seen_wr) begin seen_wr = 1; wr_k = k; end
      end
      if (rsp_valid) begin
        lat = k; g_err = rsp_err; got = rsp_rdata;
        break;
      end
      @(posedge clk);
    end
    chk({tag, ":latency"}, lat, e_lat);
    chk({tag, ":err"}, 32'(g_err), 32'(e_err));
    chk({tag, ":rdata"}, got, e_rd);
    chk({tag, ":mem_en_seen"}, 32'(seen_en), 32'(!e_err));
    chk({tag, ":write_seen"}, 32'(seen_wr), 32'(e_wr));
    if (seen_en && !e_err) chk({tag, ":mem_addr"}, g_idx, e_idx);
    if (e_wr) chk({tag, ":write_cycle"}, wr_k, e_lat - 1);
    @(posedge clk);
    #1;
    chk({tag, ":pulse_end"}, 32'(rsp_valid), 32'd0);
  endtask

  task automatic do_op(input string tag, input bit we, input logic [1:0] size, input bit sgn,
                       input logic [31:0] addr, input logic [31:0] wdata, output logic [31:0] got);
    bit e; logic [31:0] rd, idx; int lat;
    ref_req(we, size, sgn, addr, wdata, e, rd, lat, idx);
    @(negedge clk);
    chk({tag, ":ready"}, 32'(req_ready), 32'd1);
    drive(we, size, sgn, addr, wdata);
    @(posedge clk);
    collect(tag, e, rd, lat, idx, we && !e, got);
    if (we && !e) chk({tag, ":ram"}, ram_rd(int'(idx)), ref_rd(int'(idx)));
  endtask

  initial begin
    logic [31:0] got;
    bit e; logic [31:0] rd, idx; int lat;
    bit seen;

    // reset values
    #2;
    chk("rst:req_ready", 32'(req_ready), 32'd1);
    chk("rst:rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst:rsp_err", 32'(rsp_err), 32'd0);
    chk("rst:rsp_rdata", rsp_rdata, 32'd0);
    chk("rst:mem_en", 32'(mem_en), 32'd0);
    chk("rst:mem_wen", 32'(mem_wen), 32'd0);
    chk("rst:mem_addr", 32'(mem_addr), 32'd0);
    chk("rst:mem_din", mem_din, 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // word store then load
    do_op("sw14", 1, 2'd2, 0, 32'h14, 32'hDEADBEEF, got);
    do_op("lw14", 0, 2'd2, 0, 32'h14, 32'h0, got);
    chk("lw14:const", got, 32'hDEADBEEF);

    // byte read-modify-write and sub-word loads
    do_op("sw14b", 1, 2'd2, 0, 32'h14, 32'h11223344, got);
    do_op("sb15", 1, 2'd0, 0, 32'h15, 32'h000000AA, got);
    chk("sb15:word", ram_rd(5), 32'h11AA3344);
    do_op("lb15", 0, 2'd0, 1, 32'h15, 32'h0, got);
    chk("lb15:const", got, 32'hFFFFFFAA);
    do_op("lbu15", 0, 2'd0, 0, 32'h15, 32'h0, got);
    chk("lbu15:const", got, 32'h000000AA);
    do_op("lh16", 0, 2'd1, 1, 32'h16, 32'h0, got);
    chk("lh16:const", got, 32'h00003344);
    do_op("lh17", 0, 2'd1, 1, 32'h17, 32'h0, got);
    do_op("sh16", 1, 2'd1, 0, 32'h16, 32'h1234BEEF, got);
    do_op("rsvd", 0, 2'd3, 0, 32'h10, 32'h0, got);
    do_op("swmis", 1, 2'd2, 0, 32'h12, 32'h55, got);

    // address range edge
    do_op("lw_top", 0, 2'd2, 0, 32'(51199 * 4), 32'h0, got);
    do_op("lw_over", 0, 2'd2, 0, 32'(51200 * 4), 32'h0, got);

    // req_valid held across a busy load; second request only taken once back in IDLE
    ref_req(0, 2'd2, 0, 32'h14, 32'h0, e, rd, lat, idx);
    @(negedge clk);
    drive(0, 2'd2, 0, 32'h14, 32'h0);
    @(posedge clk);
    for (int k = 1; k <= 4; k++) begin
      #1;
      if (k == 1) drive(0, 2'd0, 0, 32'h17, 32'h0);
      chk("hold:ready", 32'(req_ready), 32'(k == 4));
      chk("hold:rsp_valid", 32'(rsp_valid), 32'(k == 3));
      if (k == 3) chk("hold:rdataA", rsp_rdata, rd);
      if (k < 4) @(posedge clk);
    end
    ref_req(0, 2'd0, 0, 32'h17, 32'h0, e, rd, lat, idx);
    @(posedge clk);
    collect("holdB", e, rd, lat, idx, 0, got);

    // reset asserted while a load sits in WAIT
    @(negedge clk);
    drive(0, 2'd2, 0, 32'h14, 32'h0);
    @(posedge clk); #1; req_valid = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("rstwait:mem_en", 32'(mem_en), 32'd0);
    chk("rstwait:ready", 32'(req_ready), 32'd1);
    chk("rstwait:rsp_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (rsp_valid || mem_en) seen = 1;
    end
    chk("rstwait:no_activity", 32'(seen), 32'd0);

    // random traffic
    for (int n = 0; n < 300; n++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 63));
      do_op("rand", 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            a, $urandom, got);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
